miriscv_mul: RTL and testbench
==============================

// Module: miriscv_mul
// PURPOSE
// - Sequential radix-2 shift-add multiplier; the MDU multiply path, counterpart of the divide path.
// - Executes MUL, MULH, MULHSU and MULHU (RV32M).
// - Stalls the pipeline through mul_stall_req_o until the result is ready.
// - Presents the same start/kill/keep/stall contract to the MDU as the divider.
// PARAMETERS
// - EARLY_OUT  1  1: a zero operand skips iteration; 0: always runs the full XLEN iterations.
// - XLEN       -  not a parameter; taken from miriscv_pkg::XLEN (32).
// PORTS
// - clk_i            in   1             Clock; all state updates on posedge.
// - arstn_i          in   1             Reset; asynchronous, active-low.
// - mul_start_i      in   1             Multiply requested; held high by the MDU until the result is taken.
// - port_a_i         in   XLEN          Multiplicand (rs1).
// - port_b_i         in   XLEN          Multiplier (rs2).
// - mdu_op_i         in   MDU_OP_WIDTH  MDU_MUL / MDU_MULH / MDU_MULHSU / MDU_MULHU.
// - kill_i           in   1             Flush; aborts any operation.
// - keep_i           in   1             Pipeline held; keeps the result valid in FINISH.
// - mul_result_o     out  XLEN          Low word (MUL) or high word (others) of the product.
// - mul_stall_req_o  out  1             mul_start_i && state != MUL_FINISH.
// BEHAVIOUR
// - Async reset: state=MUL_IDLE; prod/mcand/op/sign_inv/iter=0; so mul_result_o=0.
// - Reset mid-operation aborts immediately.
// - Registers:
//   - prod[2*XLEN:0] is {carry, acc, multiplier}.
//   - mcand is the XLEN-bit magnitude of A.
//   - op is the latched mdu_op_i; iter is $clog2(XLEN) bits.
// - MUL_IDLE: when mul_start_i=1, latch op and go to MUL_FIRST.
//   - A is signed for MUL/MULH/MULHSU; B is signed for MUL/MULH.
//   - Signed operands are stored as magnitude (~x+1). 0x80000000 stays 0x80000000, read as unsigned 2^31.
//   - sign_inv = (sa & a_signed) ^ (sb & b_signed). MUL also uses this sign fix.
// - MUL_FIRST: prod = {0, 0, |B|}; iter = XLEN-1.
//   - If EARLY_OUT and (|A|==0 or |B|==0): prod=0, sign_inv=0, go to MUL_FINISH. Otherwise go to MUL_COMP.
// - MUL_COMP, each cycle:
//   - sum = prod[0] ? prod[2X-1:X] + mcand : prod[2X-1:X]. The XLEN+1-bit add keeps its carry.
//   - prod = {sum, prod[X-1:1]} (one logical right shift); iter--.
//   - On iter==0: go to MUL_SIGN_CHANGE if sign_inv, else MUL_FINISH.
// - MUL_SIGN_CHANGE: prod[2X-1:0] = ~prod[2X-1:0] + 1 (64-bit two's complement); go to MUL_FINISH.
// - MUL_FINISH: result stable, stall low. Next state is MUL_IDLE if !keep_i, else stay in MUL_FINISH.
// - mul_result_o = (op==MDU_MUL) ? prod[X-1:0] : prod[2X-1:X]. Combinational from registers.
// - Latency from the start cycle (IDLE counts as 1), stall high for:
//   - XLEN+2 cycles unsigned/positive;
//   - XLEN+3 cycles with sign fix;
//   - 2 cycles early-out.
// - kill_i: synchronous, highest priority; next state MUL_IDLE from any state; datapath registers unchanged.
//   - Stall then tracks mul_start_i (a restart begins the next cycle).
// - mul_start_i low before FINISH is illegal; the FSM completes anyway and returns to IDLE after FINISH.
// - An unknown mdu_op_i while in IDLE is treated as MULHU; the MDU never issues it.
// - Operand ports are sampled only in IDLE; changes later are ignored.
// STRUCTURE
// - miriscv_mdu_pkg: add typedef enum logic[2:0] mul_state_t {MUL_IDLE, MUL_FIRST, MUL_COMP,
//   MUL_SIGN_CHANGE, MUL_FINISH}. MDU_* op codes already live there.
// - Single module, no sub-module; the adder and negator are inline.
// - Two always blocks: an FSM register plus next-state comb, and a datapath always_ff.
//   Both use async arstn_i.
// TESTING (XLEN=32)
// - MULHU A=B=0xFFFFFFFF -> result 0xFFFFFFFE; stall high exactly 34 cycles.
// - MUL A=0xFFFFFFF9 (-7), B=3 -> 0xFFFFFFEB; SIGN_CHANGE visited; stall 35 cycles.
// - MULH A=B=0x80000000 -> 0x40000000; MUL with the same operands -> 0x00000000.
// - MULHSU A=0xFFFFFFFF (-1), B=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF; MULHU with the same operands -> 0xFFFFFFFE.
// - MUL A=0, B=0x1234, EARLY_OUT=1 -> 0 after 2 stall cycles.
//   - Same with EARLY_OUT=0 -> 0 after 34 cycles.
// - kill_i during COMP iteration 10 -> IDLE next cycle; restart MUL 6*7 -> 42.
//   - keep_i=1 for 5 cycles in FINISH -> result held, stall low.
//   - arstn_i low mid-COMP -> output 0 immediately (async).

Source files
------------

// File: rtl/miriscv_mdu_pkg.sv
// MDU operation codes and the state encoding of the sequential multiplier.
package miriscv_mdu_pkg;

    localparam int MDU_OP_WIDTH = 3;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

    typedef enum logic [2:0] {
        MUL_IDLE,
        MUL_FIRST,
        MUL_COMP,
        MUL_SIGN_CHANGE,
        MUL_FINISH
    } mul_state_t;

endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide constants shared by the execution units.
package miriscv_pkg;

    localparam int XLEN = 32;

endpackage

// File: rtl/miriscv_mul.sv
// Sequential radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are multiplied as magnitudes and the 64-bit product is negated at the end when needed.
module miriscv_mul
    import miriscv_pkg::XLEN;
    import miriscv_mdu_pkg::*;
#(
    parameter bit EARLY_OUT = 1'b1
)
(
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    mul_start_i,
    input  logic [XLEN-1:0]         port_a_i,
    input  logic [XLEN-1:0]         port_b_i,
    input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
    input  logic                    kill_i,
    input  logic                    keep_i,
    output logic [XLEN-1:0]         mul_result_o,
    output logic                    mul_stall_req_o
);

    localparam int ITER_W = $clog2(XLEN);

    mul_state_t              state_reg;
    mul_state_t              state_next;
    logic [2*XLEN:0]         prod_reg;
    logic [XLEN-1:0]         mcand_reg;
    logic [MDU_OP_WIDTH-1:0] op_reg;
    logic                    sign_inv_reg;
    logic [ITER_W-1:0]       iter_reg;

    logic [MDU_OP_WIDTH-1:0] op_in;
    logic                    a_signed;
    logic                    b_signed;
    logic [XLEN-1:0]         mag_a;
    logic [XLEN-1:0]         mag_b;
    logic [XLEN:0]           sum;
    logic                    early_zero;

    // Anything that is not a multiply op is executed as MULHU.
    always_comb begin
        op_in = MDU_MULHU;
        if (mdu_op_i == MDU_MUL || mdu_op_i == MDU_MULH || mdu_op_i == MDU_MULHSU)
            op_in = mdu_op_i;
        a_signed = (op_in != MDU_MULHU);
        b_signed = (op_in == MDU_MUL) || (op_in == MDU_MULH);
        mag_a    = (a_signed && port_a_i[XLEN-1]) ? ~port_a_i + XLEN'(1) : port_a_i;
        mag_b    = (b_signed && port_b_i[XLEN-1]) ? ~port_b_i + XLEN'(1) : port_b_i;
    end

    // The adder is XLEN+1 bits wide so its carry shifts into the accumulator MSB.
    assign sum = prod_reg[0] ? {1'b0, prod_reg[2*XLEN-1:XLEN]} + {1'b0, mcand_reg}
                             : {1'b0, prod_reg[2*XLEN-1:XLEN]};

    assign early_zero = EARLY_OUT && ((mcand_reg == '0) || (prod_reg[XLEN-1:0] == '0));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MUL_IDLE:        if (mul_start_i) state_next = MUL_FIRST;
            MUL_FIRST:       state_next = early_zero ? MUL_FINISH : MUL_COMP;
            MUL_COMP:        if (iter_reg == '0)
                                 state_next = sign_inv_reg ? MUL_SIGN_CHANGE : MUL_FINISH;
            MUL_SIGN_CHANGE: state_next = MUL_FINISH;
            MUL_FINISH:      if (!keep_i) state_next = MUL_IDLE;
            default:         state_next = MUL_IDLE;
        endcase
        if (kill_i)
            state_next = MUL_IDLE;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)
            state_reg <= MUL_IDLE;
        else
            state_reg <= state_next;
    end

    // A kill only redirects the FSM; the datapath keeps whatever it holds.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            prod_reg     <= '0;
            mcand_reg    <= '0;
            op_reg       <= '0;
            sign_inv_reg <= 1'b0;
            iter_reg     <= '0;
        end else if (!kill_i) begin
            case (state_reg)
                MUL_IDLE: begin
                    if (mul_start_i) begin
                        op_reg       <= op_in;
                        mcand_reg    <= mag_a;
                        sign_inv_reg <= (port_a_i[XLEN-1] & a_signed) ^ (port_b_i[XLEN-1] & b_signed);
                        prod_reg     <= {{(XLEN+1){1'b0}}, mag_b};
                    end
                end
                MUL_FIRST: begin
                    iter_reg <= ITER_W'(XLEN-1);
                    if (early_zero) begin
                        prod_reg     <= '0;
                        sign_inv_reg <= 1'b0;
                    end else begin
                        prod_reg <= {{(XLEN+1){1'b0}}, prod_reg[XLEN-1:0]};
                    end
                end
                MUL_COMP: begin
                    prod_reg <= {1'b0, sum, prod_reg[XLEN-1:1]};
                    iter_reg <= iter_reg - ITER_W'(1);
                end
                MUL_SIGN_CHANGE: begin
                    prod_reg <= {prod_reg[2*XLEN], ~prod_reg[2*XLEN-1:0] + (2*XLEN)'(1)};
                end
                default: ;
            endcase
        end
    end

    assign mul_result_o    = (op_reg == MDU_MUL) ? prod_reg[XLEN-1:0] : prod_reg[2*XLEN-1:XLEN];
    assign mul_stall_req_o = mul_start_i && (state_reg != MUL_FINISH);

endmodule

// File: tb/tb_miriscv_mul.sv
// Bench for miriscv_mul: directed corner cases plus random ops against a plain-arithmetic model,
// run on one instance with early-out enabled and one without.
module tb_miriscv_mul;
    import miriscv_pkg::XLEN;
    import miriscv_mdu_pkg::*;

    logic        clk    = 1'b0;
    logic        arst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start0 = 1'b0;
    logic        kill   = 1'b0;
    logic        keep   = 1'b0;
    logic [31:0] a      = '0;
    logic [31:0] b      = '0;
    logic [2:0]  op     = '0;
    logic [31:0] res1, res0;
    logic        stall1, stall0;
    logic [31:0] exp1 = '0;
    logic [31:0] exp0 = '0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    miriscv_mul #(.EARLY_OUT(1'b1)) u_eo1 (
        .clk_i(clk), .arstn_i(arst_n), .mul_start_i(start1), .port_a_i(a), .port_b_i(b),
        .mdu_op_i(op), .kill_i(kill), .keep_i(keep), .mul_result_o(res1), .mul_stall_req_o(stall1)
    );

    miriscv_mul #(.EARLY_OUT(1'b0)) u_eo0 (
        .clk_i(clk), .arstn_i(arst_n), .mul_start_i(start0), .port_a_i(a), .port_b_i(b),
        .mdu_op_i(op), .kill_i(kill), .keep_i(keep), .mul_result_o(res0), .mul_stall_req_o(stall0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic logic [2:0] eff_op(input logic [2:0] opc);
        if (opc == MDU_MUL || opc == MDU_MULH || opc == MDU_MULHSU) return opc;
        return MDU_MULHU;
    endfunction

    // Reference: full-precision signed product of the sign/zero-extended operands.
    function automatic logic [31:0] model_res(input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y);
        logic signed [65:0] ex, ey, p;
        logic [2:0] o;
        o  = eff_op(opc);
        ex = (o != MDU_MULHU) ? {{34{x[31]}}, x} : {34'b0, x};
        ey = (o == MDU_MUL || o == MDU_MULH) ? {{34{y[31]}}, y} : {34'b0, y};
        p  = ex * ey;
        return (o == MDU_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_lat(input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y, input bit eo);
        logic [2:0] o;
        bit as, bs;
        o  = eff_op(opc);
        as = (o != MDU_MULHU);
        bs = (o == MDU_MUL || o == MDU_MULH);
        if (eo && (x == 0 || y == 0)) return 2;
        return 34 + int'((x[31] & as) ^ (y[31] & bs));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Result check on every FINISH cycle of either instance.
    always @(negedge clk) begin
        if (arst_n && start1 && !stall1) check("res_eo1", res1, exp1);
        if (arst_n && start0 && !stall0) check("res_eo0", res0, exp0);
    end

    task automatic start_op(input bit sel, input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y, input bit hold);
        a = x; b = y; op = opc; keep = hold;
        if (sel) begin exp1 = model_res(opc, x, y); start1 = 1'b1; end
        else     begin exp0 = model_res(opc, x, y); start0 = 1'b1; end
    endtask

    task automatic wait_finish(input bit sel, input int exp_lat, input int keep_n, input string name);
        int cnt = 0;
        #1;
        while ((sel ? stall1 : stall0) && cnt < 200) begin
            cnt++;
            @(negedge clk); #2;
        end
        tests++;
        if (cnt != exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, cnt, exp_lat);
        end
        $display("[TB] %s eo=%0d op=%0d a=%08h b=%08h res=%08h stall_cycles=%0d",
                 name, sel, op, a, b, sel ? res1 : res0, cnt);
        for (int k = 0; k < keep_n; k++) begin
            @(negedge clk); #2;
            check("stall_keep", 32'(sel ? stall1 : stall0), 32'd0);
        end
        keep = 1'b0; start1 = 1'b0; start0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run(input bit sel, input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y,
                       input int keep_n, input string name);
        @(negedge clk); #1;
        start_op(sel, opc, x, y, keep_n > 0);
        wait_finish(sel, model_lat(opc, x, y, sel), keep_n, name);
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic [2:0]  ro;

        repeat (3) @(posedge clk);
        #1;
        check("rst_res_eo1", res1, 32'h0);
        check("rst_res_eo0", res0, 32'h0);
        check("rst_stall", 32'(stall1 | stall0), 32'h0);
        @(negedge clk); arst_n = 1'b1;

        check("pin_mulhu",   model_res(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_mul_neg", model_res(MDU_MUL,    32'hFFFF_FFF9, 32'h3),         32'hFFFF_FFEB);
        check("pin_mulh_mn", model_res(MDU_MULH,   32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("pin_mulhsu",  model_res(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("pin_lat_neg", 32'(model_lat(MDU_MUL, 32'hFFFF_FFF9, 32'h3, 1'b1)), 32'd35);
        check("pin_lat_eo",  32'(model_lat(MDU_MUL, 32'h0, 32'h1234, 1'b1)),      32'd2);

        run(1'b1, MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
        run(1'b1, MDU_MUL,    32'hFFFF_FFF9, 32'h0000_0003, 0, "mul_neg7x3");
        run(1'b1, MDU_MULH,   32'h8000_0000, 32'h8000_0000, 0, "mulh_minmin");
        run(1'b1, MDU_MUL,    32'h8000_0000, 32'h8000_0000, 0, "mul_minmin");
        run(1'b1, MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
        run(1'b1, MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_m1");
        run(1'b1, MDU_MUL,    32'h0,         32'h0000_1234, 0, "mul_zero_eo");
        run(1'b0, MDU_MUL,    32'h0,         32'h0000_1234, 0, "mul_zero_full");
        run(1'b0, MDU_MULH,   32'hFFFF_FFF9, 32'h0,         0, "mulh_negzero_full");
        run(1'b1, MDU_DIVU,   32'h1234_5678, 32'h9ABC_DEF0, 0, "unknown_op");

        // Kill during the tenth COMP cycle, then restart 6*7 from IDLE.
        @(negedge clk); #1;
        start_op(1'b1, MDU_MULHU, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
        repeat (11) @(negedge clk);
        #1;
        kill = 1'b1;
        a = 32'd6; b = 32'd7; op = MDU_MUL; exp1 = model_res(MDU_MUL, 32'd6, 32'd7);
        @(negedge clk); #1;
        kill = 1'b0;
        wait_finish(1'b1, 34, 0, "kill_restart");
        check("pin_6x7", model_res(MDU_MUL, 32'd6, 32'd7), 32'd42);

        run(1'b1, MDU_MUL, 32'd6, 32'd7, 5, "keep_hold");

        // Asynchronous reset in the middle of COMP clears the result at once.
        @(negedge clk); #1;
        start_op(1'b1, MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (15) @(negedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        check("async_rst_res", res1, 32'h0);
        start1 = 1'b0;
        @(negedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            rx = pick();
            ry = pick();
            ro = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            run((i % 4) != 0, ro, rx, ry, $urandom_range(0, 2), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
